// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemValid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemValid,
    output imemRdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem handshake, held instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              resetN,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              instrValid,
  input  logic              instrAccept,
  input  logic              pcSrc,
  input  logic              jump,
  input  logic [31:0]       signImm,
  output logic [31:0]       pc,
  output logic [31:0]       pcPlus4,
  output logic [CNT_W-1:0]  retiredCount
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        next_pc;

  // Sequential state; reset abandons any in-flight request by returning to BOOT
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect target for the held instruction: jump beats branch beats fall-through
  always_comb begin
    pcPlus4 = pc_q + 32'd4;
    if (jump) begin
      next_pc = {pcPlus4[31:28], instr_q[25:0], 2'b00};
    end else if (pcSrc) begin
      next_pc = pcPlus4 + {signImm[29:0], 2'b00};
    end else begin
      next_pc = pcPlus4;
    end
  end

  // Next-state and capture logic; memory response only honoured in WAIT, accept only in HOLD
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (imem.imemValid) begin
          instr_d = imem.imemRdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instrAccept) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Outputs are decoded from registered state only; op/funct never bypass the instr register
  always_comb begin
    imem.imemReq  = (state_q == WAIT);
    imem.imemAddr = pc_q;
    instrValid    = (state_q == HOLD);
    instr         = instr_q;
    op            = instr_q[31:26];
    funct         = instr_q[5:0];
    pc            = pc_q;
    retiredCount  = cnt_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk;
  logic        resetN;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instrValid;
  logic        instrAccept;
  logic        pcSrc;
  logic        jump;
  logic [31:0] signImm;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] retiredCount;

  int total;
  int bad;

  fetch_unit_if imem_bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .imem         (imem_bus.master),
    .instr        (instr),
    .op           (op),
    .funct        (funct),
    .instrValid   (instrValid),
    .instrAccept  (instrAccept),
    .pcSrc        (pcSrc),
    .jump         (jump),
    .signImm      (signImm),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .retiredCount (retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In WAIT at a negedge: present a same-cycle response, end in HOLD at the next negedge
  task automatic fetch_word(input logic [31:0] word);
    imem_bus.imemValid = 1'b1;
    imem_bus.imemRdata = word;
    @(negedge clk);
    imem_bus.imemValid = 1'b0;
  endtask

  // In HOLD at a negedge: accept with the given redirect, end in WAIT at the next negedge
  task automatic accept_with(input logic j, input logic b, input logic [31:0] imm);
    jump        = j;
    pcSrc       = b;
    signImm     = imm;
    instrAccept = 1'b1;
    @(negedge clk);
    instrAccept = 1'b0;
    jump        = 1'b0;
    pcSrc       = 1'b0;
    signImm     = 32'h0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (imem_bus.imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", imem_bus.imemReq); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", instrValid); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 00000000", pc); end
    total++; if (retiredCount !== 32'h0) begin bad++; $display("FAIL reset_cnt got %0d want 0", retiredCount); end
    resetN = 1'b1;
    #1;
    total++; if (imem_bus.imemReq !== 1'b0) begin bad++; $display("FAIL boot_req got %b want 0", imem_bus.imemReq); end
    @(negedge clk);
    total++; if (imem_bus.imemReq !== 1'b1) begin bad++; $display("FAIL wait_req got %b want 1", imem_bus.imemReq); end
    total++; if (imem_bus.imemAddr !== 32'h0) begin bad++; $display("FAIL wait_addr got %h want 00000000", imem_bus.imemAddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    imem_bus.imemValid = 1'b1;
    imem_bus.imemRdata = 32'h012A_4020;
    instrAccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL seq_wait_valid[%0d] got %b want 0", i, instrValid); end
      total++; if (imem_bus.imemAddr !== exp_pc) begin bad++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_bus.imemAddr, exp_pc); end
      @(negedge clk);
      total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL seq_hold_valid[%0d] got %b want 1", i, instrValid); end
      total++; if (op !== 6'h00) begin bad++; $display("FAIL seq_op[%0d] got %h want 00", i, op); end
      total++; if (funct !== 6'h20) begin bad++; $display("FAIL seq_funct[%0d] got %h want 20", i, funct); end
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc); end
      @(negedge clk);
      exp_pc = exp_pc + 32'd4;
    end
    imem_bus.imemValid = 1'b0;
    instrAccept = 1'b0;
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL seq_final_pc got %h want 0000000c", pc); end
    total++; if (retiredCount !== 32'd3) begin bad++; $display("FAIL seq_cnt got %0d want 3", retiredCount); end
  endtask

  task automatic test_stall();
    imem_bus.imemValid = 1'b0;
    imem_bus.imemRdata = 32'h8C01_0004;
    for (int i = 0; i < 5; i++) begin
      total++; if (imem_bus.imemReq !== 1'b1) begin bad++; $display("FAIL stall_req[%0d] got %b want 1", i, imem_bus.imemReq); end
      total++; if (imem_bus.imemAddr !== 32'hC) begin bad++; $display("FAIL stall_addr[%0d] got %h want 0000000c", i, imem_bus.imemAddr); end
      total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL stall_valid[%0d] got %b want 0", i, instrValid); end
      @(negedge clk);
    end
    fetch_word(32'h8C01_0004);
    total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL stall_capture_valid got %b want 1", instrValid); end
    total++; if (instr !== 32'h8C01_0004) begin bad++; $display("FAIL stall_instr got %h want 8c010004", instr); end
    total++; if (op !== 6'h23) begin bad++; $display("FAIL stall_op got %h want 23", op); end
    imem_bus.imemValid = 1'b1;
    imem_bus.imemRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_bus.imemValid = 1'b0;
    total++; if (instr !== 32'h8C01_0004) begin bad++; $display("FAIL hold_ignores_resp got %h want 8c010004", instr); end
    total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL hold_stays got %b want 1", instrValid); end
    accept_with(1'b0, 1'b0, 32'h0);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL stall_next_pc got %h want 00000010", pc); end
    total++; if (retiredCount !== 32'd4) begin bad++; $display("FAIL stall_cnt got %0d want 4", retiredCount); end
  endtask

  task automatic test_branch();
    fetch_word(32'h0800_0010);
    accept_with(1'b1, 1'b0, 32'h0);
    total++; if (imem_bus.imemAddr !== 32'h40) begin bad++; $display("FAIL jump_to_40 got %h want 00000040", imem_bus.imemAddr); end
    fetch_word(32'h1000_FFFE);
    pcSrc   = 1'b1;
    signImm = 32'hFFFF_FFFE;
    @(negedge clk);
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL branch_no_accept_pc got %h want 00000040", pc); end
    total++; if (retiredCount !== 32'd5) begin bad++; $display("FAIL branch_no_accept_cnt got %0d want 5", retiredCount); end
    total++; if (pcPlus4 !== 32'h44) begin bad++; $display("FAIL branch_pcplus4 got %h want 00000044", pcPlus4); end
    accept_with(1'b0, 1'b1, 32'hFFFF_FFFE);
    total++; if (imem_bus.imemAddr !== 32'h3C) begin bad++; $display("FAIL branch_target got %h want 0000003c", imem_bus.imemAddr); end
    total++; if (retiredCount !== 32'd6) begin bad++; $display("FAIL branch_cnt got %0d want 6", retiredCount); end
  endtask

  task automatic test_jump_priority();
    fetch_word(32'h1000_0000);
    accept_with(1'b0, 1'b1, 32'h03FF_FFF4);
    total++; if (pc !== 32'h1000_0010) begin bad++; $display("FAIL far_branch got %h want 10000010", pc); end
    fetch_word(32'h0800_0100);
    accept_with(1'b1, 1'b1, 32'h0000_0123);
    total++; if (pc !== 32'h1000_0400) begin bad++; $display("FAIL jump_priority got %h want 10000400", pc); end
    total++; if (retiredCount !== 32'd8) begin bad++; $display("FAIL jump_cnt got %0d want 8", retiredCount); end
  endtask

  task automatic test_pc_wrap();
    fetch_word(32'h1000_0000);
    accept_with(1'b0, 1'b1, 32'h3BFF_FEFE);
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL to_top_pc got %h want fffffffc", pc); end
    total++; if (pcPlus4 !== 32'h0) begin bad++; $display("FAIL pcplus4_wrap got %h want 00000000", pcPlus4); end
    fetch_word(32'h0000_0020);
    accept_with(1'b0, 1'b0, 32'h0);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got %h want 00000000", pc); end
    instrAccept = 1'b1;
    jump        = 1'b1;
    @(negedge clk);
    instrAccept = 1'b0;
    jump        = 1'b0;
    total++; if (retiredCount !== 32'd10) begin bad++; $display("FAIL accept_in_wait_cnt got %0d want 10", retiredCount); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL accept_in_wait_pc got %h want 00000000", pc); end
  endtask

  task automatic test_reset_mid_request();
    total++; if (imem_bus.imemReq !== 1'b1) begin bad++; $display("FAIL mid_pre_req got %b want 1", imem_bus.imemReq); end
    resetN = 1'b0;
    #1;
    total++; if (imem_bus.imemReq !== 1'b0) begin bad++; $display("FAIL mid_async_req got %b want 0", imem_bus.imemReq); end
    total++; if (retiredCount !== 32'd0) begin bad++; $display("FAIL mid_async_cnt got %0d want 0", retiredCount); end
    imem_bus.imemValid = 1'b1;
    imem_bus.imemRdata = 32'h1111_1111;
    repeat (2) @(negedge clk);
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_reset_instr got %h want 00000000", instr); end
    resetN = 1'b1;
    #1;
    total++; if (imem_bus.imemReq !== 1'b0) begin bad++; $display("FAIL mid_boot_req got %b want 0", imem_bus.imemReq); end
    @(negedge clk);
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_boot_ignored got %h want 00000000", instr); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL mid_boot_valid got %b want 0", instrValid); end
    total++; if (imem_bus.imemAddr !== 32'h0) begin bad++; $display("FAIL mid_restart_addr got %h want 00000000", imem_bus.imemAddr); end
    @(negedge clk);
    imem_bus.imemValid = 1'b0;
    total++; if (instr !== 32'h1111_1111) begin bad++; $display("FAIL mid_refetch got %h want 11111111", instr); end
    total++; if (retiredCount !== 32'd0) begin bad++; $display("FAIL mid_cnt got %0d want 0", retiredCount); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetN             = 1'b0;
    instrAccept        = 1'b0;
    pcSrc              = 1'b0;
    jump               = 1'b0;
    signImm            = 32'h0;
    imem_bus.imemValid = 1'b0;
    imem_bus.imemRdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_pc_wrap();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control path.
- Owns the PC and drives a variable-latency instruction-memory request/response interface.
- Holds the fetched instruction and presents its op/funct fields to the decoder until execute accepts it.
- On accept, computes the next PC from the decoder's redirect signals (pcSrc, jump) and the sign-extended immediate.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- resetN  in  1  Asynchronous, active-low reset.
- imemReq  out  1  Instruction-memory request; high while awaiting a response.
- imemAddr  out  32  Fetch address; equals pc.
- imemValid  in  1  Response valid; sampled only while imemReq=1.
- imemRdata  in  32  Instruction word; captured when imemReq & imemValid.
- instr  out  32  Held instruction.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instrValid  out  1  Held instruction is valid for decode/execute.
- instrAccept  in  1  Execute has consumed the held instruction; pcSrc, jump and signImm are qualified by it.
- pcSrc  in  1  Take the branch (branch & zero) for the held instruction.
- jump  in  1  Take the jump for the held instruction.
- signImm  in  32  Sign-extended immediate of the held instruction.
- pc  out  32  PC of the held or in-flight instruction.
- pcPlus4  out  32  pc + 4.
- retiredCount  out  CNT_W  Number of accepted instructions.

Behaviour:
- Reset (resetN=0, asynchronous, effective at any time including mid-request):
  - state=BOOT, pc=RESET_PC, instr=0, retiredCount=0.
  - imemReq=0, instrValid=0.
  - Any outstanding memory response is abandoned; an imemValid arriving during or after reset while in BOOT is ignored.
- State machine, 3 states:
  - BOOT: imemReq=0, instrValid=0. Goes to WAIT on the next edge after resetN=1.
  - WAIT: imemReq=1, imemAddr=pc held stable, instrValid=0.
    - On an edge with imemValid=1: instr<=imemRdata, go to HOLD.
    - Otherwise stay in WAIT with no timeout.
    - A combinational same-cycle response is legal.
  - HOLD: imemReq=0, instrValid=1, instr/op/funct/pc stable.
    - On an edge with instrAccept=1: pc<=nextPc, retiredCount<=retiredCount+1 (wraps to 0 at 2^CNT_W), go to WAIT.
    - instrAccept may be high in the first HOLD cycle.
- nextPc priority:
  - jump=1: {pcPlus4[31:28], instr[25:0], 2'b00}.
  - else pcSrc=1: pcPlus4 + (signImm<<2), 32-bit modulo.
  - else: pcPlus4.
  - jump and pcSrc both high: jump wins.
- pcPlus4 is combinational, pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- pcSrc, jump and signImm are ignored unless state=HOLD and instrAccept=1.
- instrAccept outside HOLD is ignored; no count increment, no PC change.
- imemValid outside WAIT is ignored; instr is not overwritten.
- Throughput: best case one instruction per 2 cycles, i.e. a WAIT cycle with immediate imemValid followed by a HOLD cycle with immediate accept.
- Latency: imemValid edge to instrValid=1 is exactly 1 cycle.
- op and funct are always slices of the registered instr; never driven from imemRdata directly.

Test Plan:
- Reset/boot, with RESET_PC=0:
  - resetN low → imemReq=0, instrValid=0, pc=0, retiredCount=0.
  - First cycle after release is BOOT, then imemReq=1 with imemAddr=0.
- Sequential fetch, memory responding same cycle with 32'h012A4020 (add) and accept held high:
  - instrValid toggles every other cycle; op=0, funct=6'h20.
  - pc goes 0→4→8; retiredCount=3 after three accepts.
- Memory stall: imemValid withheld 5 cycles → imemReq and imemAddr stay stable for all 5 cycles; instrValid=0 throughout; instr captured on the 6th.
- Branch taken: pc=32'h40, signImm=32'hFFFF_FFFE, pcSrc=1 at accept → next imemAddr=32'h3C.
  - Same case with pcSrc=1 but instrAccept=0 → pc stays 32'h40.
- Jump priority: pc=32'h1000_0010, instr=32'h0800_0100, jump=1 and pcSrc=1 → next pc=32'h1000_0400.
- Reset mid-request: resetN asserted while in WAIT with the response pending.
  - Response arriving during BOOT is ignored.
  - After release, fetch restarts at RESET_PC with retiredCount=0.
